d_cache_request_buffer: RTL and testbench
=========================================

D_CACHE_REQUEST_BUFFER -- requirements
Module: d_cache_request_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 Parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 Parameter DATA_WIDTH, default 32, data width.
REQ-004 Parameter AL_ID_WIDTH, default 6, active-list id width.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset; synchronous, active-high.
REQ-007 Port req_valid, input, 1: the load/store queue offers a request.
REQ-008 Port req_ready, output, 1: the buffer accepts the offered request this cycle.
REQ-009 Port req_is_store, input, 1: 1 means store, 0 means load.
REQ-010 Ports req_addr, req_data, req_al_id, inputs, ADDR_WIDTH / DATA_WIDTH / AL_ID_WIDTH: request payload.
REQ-011 Port cache_valid, output, 1: a request is presented to the d-cache.
REQ-012 Port cache_ready, input, 1: the d-cache accepts the presented request.
REQ-013 Ports cache_is_store, cache_addr, cache_data, outputs: presented request payload.
REQ-014 Ports cache_resp_valid (input, 1) and cache_resp_data (input, DATA_WIDTH): completion from the d-cache; load data, or a write acknowledge for stores.
REQ-015 Ports ld_done_valid, ld_done_data, ld_done_al_id, outputs: load writeback.
REQ-016 Ports st_done_valid and st_done_al_id, outputs: store completion.
REQ-017 Port flush, input, 1: branch-mispredict squash of uncommitted loads.
REQ-018 Port occupancy, output, log2(DEPTH)+1 bits: number of valid FIFO entries.

Function
REQ-019 The FIFO push fires on req_valid && req_ready, and req_ready = !full && !flush.
REQ-020 The ready signal uses the current-cycle full flag; a push into a full FIFO is not accepted in the same cycle as a pop.
REQ-021 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty come from occupancy.
REQ-022 The FSM has states IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when the FIFO is non-empty and the head entry is not killed.
- ISSUE holds cache_valid=1 with a stable payload until cache_ready; it then pops the head and moves to WAIT.
- WAIT -> IDLE on cache_resp_valid.
REQ-023 In IDLE, a killed head entry is popped without issuing, at one entry per cycle.
REQ-024 Minimum latency is 3 cycles: a push in cycle N is issued in N+1 when the FIFO was empty in IDLE, and done_valid is asserted in the cycle after cache_resp_valid.
REQ-025 ld_done_valid and st_done_valid are one-cycle registered pulses carrying the in-flight al_id and cache_resp_data.
REQ-026 Only one request is outstanding at a time; cache_valid=0 in WAIT and IDLE.
REQ-027 Flush sets the killed bit on every valid load entry in the FIFO; store entries are unaffected.
REQ-028 Flush during WAIT with an in-flight load marks the in-flight load killed; its response is consumed and ld_done_valid is suppressed.
REQ-029 Flush during ISSUE of a load completes the handshake, then applies REQ-028.
REQ-030 A flush has no effect on an in-flight store.
REQ-031 cache_resp_valid outside WAIT is ignored.
REQ-032 Simultaneous push and pop leaves occupancy unchanged.

Reset
REQ-033 Asserting rst clears pointers, occupancy, killed bits and FSM state (to IDLE), and clears all done outputs and cache_valid to 0 on the next edge.
REQ-034 Reset mid-operation abandons any in-flight request, and its later response is ignored per REQ-031.
REQ-035 After reset, req_ready=1 and all data outputs are 0.

Structure
REQ-036 The FSM state enum and the default widths are defined in the shared mips_core package.
REQ-037 Entry storage is a sub-module, req_fifo, with push/pop and per-entry kill; the FSM and done registers live in the top module.

Verification
REQ-038 Load at addr 0x100, al_id 5, with cache_ready=1 and the response of 0xDEADBEEF two cycles later -> cache_valid in cycle 1, then ld_done_valid with data 0xDEADBEEF and al_id 5 one cycle after the response.
REQ-039 Five back-to-back pushes with cache_ready=0 -> req_ready drops after 4 accepted pushes, occupancy=4; releasing cache_ready drains in FIFO order with pointer wrap.
REQ-040 Queue [store al 1, load al 2, load al 3] then flush -> the store is issued and st_done al 1 is produced; both loads are dropped, no ld_done, occupancy reaches 0.
REQ-041 Flush while a load (al 7) is in WAIT -> the response is consumed, ld_done_valid stays 0, and the FSM returns to IDLE.
REQ-042 rst asserted during ISSUE -> the next cycle shows cache_valid=0, occupancy=0, req_ready=1; a stray cache_resp_valid produces no done pulse.
REQ-043 Push and pop in the same cycle at occupancy 2 -> occupancy stays 2.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core definitions: default datapath widths and the d-cache
// request buffer FSM state encoding.
package mips_core_pkg;

    localparam int DCRB_DEPTH      = 4;
    localparam int CORE_ADDR_WIDTH = 32;
    localparam int CORE_DATA_WIDTH = 32;
    localparam int AL_ID_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_ISSUE = 2'd1,
        DC_WAIT  = 2'd2
    } dc_state_e;

endpackage

// File: rtl/d_cache_request_buffer_req_fifo.sv
// Request FIFO for the d-cache buffer. Holds load/store entries in
// arrival order; each entry carries a killed bit that a flush sets on
// every live load so the issue logic can discard it instead of issuing.
module req_fifo
    import mips_core_pkg::*;
#(
    parameter int DEPTH       = DCRB_DEPTH,
    parameter int ADDR_WIDTH  = CORE_ADDR_WIDTH,
    parameter int DATA_WIDTH  = CORE_DATA_WIDTH,
    parameter int AL_ID_WIDTH = AL_ID_WIDTH_DEF,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   push_is_store,
    input  logic [ADDR_WIDTH-1:0]  push_addr,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic [AL_ID_WIDTH-1:0] push_al_id,
    input  logic                   pop,
    input  logic                   kill_loads,
    output logic                   head_is_store,
    output logic [ADDR_WIDTH-1:0]  head_addr,
    output logic [DATA_WIDTH-1:0]  head_data,
    output logic [AL_ID_WIDTH-1:0] head_al_id,
    output logic                   head_killed,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    logic [ADDR_WIDTH-1:0]  addr_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]  data_mem  [DEPTH];
    logic [AL_ID_WIDTH-1:0] al_id_mem [DEPTH];
    logic [DEPTH-1:0]       store_vec;
    logic [DEPTH-1:0]       killed_vec;

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_is_store = store_vec[rd_ptr_reg];
    assign head_killed   = killed_vec[rd_ptr_reg];
    assign head_addr     = addr_mem[rd_ptr_reg];
    assign head_data     = data_mem[rd_ptr_reg];
    assign head_al_id    = al_id_mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Payload storage; contents of free slots are don't-care.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_reg]  <= push_addr;
            data_mem[wr_ptr_reg]  <= push_data;
            al_id_mem[wr_ptr_reg] <= push_al_id;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic             entry_store_reg;
            logic             entry_killed_reg;
            logic [PTR_W-1:0] rel_idx;
            logic             entry_live;

            // Distance from the head decides whether this slot holds a live entry.
            assign rel_idx      = PTR_W'(gi) - rd_ptr_reg;
            assign entry_live   = ({1'b0, rel_idx} < count_reg);
            assign store_vec[gi]  = entry_store_reg;
            assign killed_vec[gi] = entry_killed_reg;

            // Per-entry type and kill flag; a fresh push always starts unkilled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_store_reg  <= 1'b0;
                    entry_killed_reg <= 1'b0;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_store_reg  <= push_is_store;
                    entry_killed_reg <= 1'b0;
                end else if (kill_loads && entry_live && !entry_store_reg) begin
                    entry_killed_reg <= 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/d_cache_request_buffer.sv
// D-cache request buffer: queues load/store requests from the LSQ,
// issues them one at a time to the d-cache, and produces load writeback
// or store completion pulses. Flushed loads are dropped silently.
module d_cache_request_buffer
    import mips_core_pkg::*;
#(
    parameter int DEPTH       = DCRB_DEPTH,
    parameter int ADDR_WIDTH  = CORE_ADDR_WIDTH,
    parameter int DATA_WIDTH  = CORE_DATA_WIDTH,
    parameter int AL_ID_WIDTH = AL_ID_WIDTH_DEF,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_store,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_data,
    input  logic [AL_ID_WIDTH-1:0] req_al_id,
    output logic                   cache_valid,
    input  logic                   cache_ready,
    output logic                   cache_is_store,
    output logic [ADDR_WIDTH-1:0]  cache_addr,
    output logic [DATA_WIDTH-1:0]  cache_data,
    input  logic                   cache_resp_valid,
    input  logic [DATA_WIDTH-1:0]  cache_resp_data,
    output logic                   ld_done_valid,
    output logic [DATA_WIDTH-1:0]  ld_done_data,
    output logic [AL_ID_WIDTH-1:0] ld_done_al_id,
    output logic                   st_done_valid,
    output logic [AL_ID_WIDTH-1:0] st_done_al_id,
    input  logic                   flush,
    output logic [CNT_W-1:0]       occupancy
);

    dc_state_e              state_reg;
    logic                   cache_valid_reg;
    logic                   cache_is_store_reg;
    logic [ADDR_WIDTH-1:0]  cache_addr_reg;
    logic [DATA_WIDTH-1:0]  cache_data_reg;
    logic [AL_ID_WIDTH-1:0] issue_al_id_reg;
    logic                   inflight_is_store_reg;
    logic                   inflight_killed_reg;
    logic [AL_ID_WIDTH-1:0] inflight_al_id_reg;
    logic                   ld_done_valid_reg;
    logic [DATA_WIDTH-1:0]  ld_done_data_reg;
    logic [AL_ID_WIDTH-1:0] ld_done_al_id_reg;
    logic                   st_done_valid_reg;
    logic [AL_ID_WIDTH-1:0] st_done_al_id_reg;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   head_is_store;
    logic                   head_killed;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [AL_ID_WIDTH-1:0] head_al_id;
    logic                   push;
    logic                   pop;
    logic                   head_issuable;

    assign req_ready = !fifo_full && !flush;
    assign push      = req_valid && req_ready;

    // A load is not launched in the same cycle a flush would kill it.
    assign head_issuable = !fifo_empty && !head_killed && !(flush && !head_is_store);

    // Pop on the issue handshake, or discard a killed head while idle.
    assign pop = ((state_reg == DC_ISSUE) && cache_ready) ||
                 ((state_reg == DC_IDLE) && !fifo_empty && head_killed);

    req_fifo #(
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .AL_ID_WIDTH (AL_ID_WIDTH)
    ) u_req_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_is_store (req_is_store),
        .push_addr     (req_addr),
        .push_data     (req_data),
        .push_al_id    (req_al_id),
        .pop           (pop),
        .kill_loads    (flush),
        .head_is_store (head_is_store),
        .head_addr     (head_addr),
        .head_data     (head_data),
        .head_al_id    (head_al_id),
        .head_killed   (head_killed),
        .count         (occupancy),
        .full          (fifo_full),
        .empty         (fifo_empty)
    );

    // Issue FSM with registered cache interface and done pulses. An empty
    // FIFO is bypassed so a fresh request is presented the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg             <= DC_IDLE;
            cache_valid_reg       <= 1'b0;
            cache_is_store_reg    <= 1'b0;
            cache_addr_reg        <= '0;
            cache_data_reg        <= '0;
            issue_al_id_reg       <= '0;
            inflight_is_store_reg <= 1'b0;
            inflight_killed_reg   <= 1'b0;
            inflight_al_id_reg    <= '0;
            ld_done_valid_reg     <= 1'b0;
            ld_done_data_reg      <= '0;
            ld_done_al_id_reg     <= '0;
            st_done_valid_reg     <= 1'b0;
            st_done_al_id_reg     <= '0;
        end else begin
            ld_done_valid_reg <= 1'b0;
            st_done_valid_reg <= 1'b0;
            unique case (state_reg)
                DC_IDLE: begin
                    if (head_issuable) begin
                        cache_valid_reg    <= 1'b1;
                        cache_is_store_reg <= head_is_store;
                        cache_addr_reg     <= head_addr;
                        cache_data_reg     <= head_data;
                        issue_al_id_reg    <= head_al_id;
                        state_reg          <= DC_ISSUE;
                    end else if (fifo_empty && push) begin
                        cache_valid_reg    <= 1'b1;
                        cache_is_store_reg <= req_is_store;
                        cache_addr_reg     <= req_addr;
                        cache_data_reg     <= req_data;
                        issue_al_id_reg    <= req_al_id;
                        state_reg          <= DC_ISSUE;
                    end
                end
                DC_ISSUE: begin
                    if (cache_ready) begin
                        cache_valid_reg       <= 1'b0;
                        inflight_is_store_reg <= cache_is_store_reg;
                        inflight_al_id_reg    <= issue_al_id_reg;
                        inflight_killed_reg   <= !cache_is_store_reg && (head_killed || flush);
                        state_reg             <= DC_WAIT;
                    end
                end
                DC_WAIT: begin
                    if (cache_resp_valid) begin
                        if (inflight_is_store_reg) begin
                            st_done_valid_reg <= 1'b1;
                            st_done_al_id_reg <= inflight_al_id_reg;
                        end else if (!inflight_killed_reg && !flush) begin
                            ld_done_valid_reg <= 1'b1;
                            ld_done_al_id_reg <= inflight_al_id_reg;
                            ld_done_data_reg  <= cache_resp_data;
                        end
                        state_reg <= DC_IDLE;
                    end else if (flush && !inflight_is_store_reg) begin
                        inflight_killed_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= DC_IDLE;
                end
            endcase
        end
    end

    assign cache_valid    = cache_valid_reg;
    assign cache_is_store = cache_is_store_reg;
    assign cache_addr     = cache_addr_reg;
    assign cache_data     = cache_data_reg;
    assign ld_done_valid  = ld_done_valid_reg;
    assign ld_done_data   = ld_done_data_reg;
    assign ld_done_al_id  = ld_done_al_id_reg;
    assign st_done_valid  = st_done_valid_reg;
    assign st_done_al_id  = st_done_al_id_reg;

endmodule

// File: tb/tb_d_cache_request_buffer.sv
// Scoreboard bench for the d-cache request buffer: a reference queue of
// accepted requests predicts issue order and done pulses; a negedge
// monitor compares whatever the DUT presents against those predictions.
module tb_d_cache_request_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [5:0]  req_al_id;
    logic        cache_valid;
    logic        cache_ready;
    logic        cache_is_store;
    logic [31:0] cache_addr;
    logic [31:0] cache_data;
    logic        cache_resp_valid;
    logic [31:0] cache_resp_data;
    logic        ld_done_valid;
    logic [31:0] ld_done_data;
    logic [5:0]  ld_done_al_id;
    logic        st_done_valid;
    logic [5:0]  st_done_al_id;
    logic        flush;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    d_cache_request_buffer #(
        .DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .AL_ID_WIDTH(6)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_data(req_data), .req_al_id(req_al_id),
        .cache_valid(cache_valid), .cache_ready(cache_ready),
        .cache_is_store(cache_is_store), .cache_addr(cache_addr), .cache_data(cache_data),
        .cache_resp_valid(cache_resp_valid), .cache_resp_data(cache_resp_data),
        .ld_done_valid(ld_done_valid), .ld_done_data(ld_done_data), .ld_done_al_id(ld_done_al_id),
        .st_done_valid(st_done_valid), .st_done_al_id(st_done_al_id),
        .flush(flush), .occupancy(occupancy)
    );

    typedef struct {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  al;
        logic        killed;
    } ent_t;

    typedef struct {
        logic        is_store;
        logic [5:0]  al;
        logic [31:0] data;
        int          due;
    } done_t;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    ent_t  mq[$];
    done_t dq[$];
    ent_t  pres;
    ent_t  infl;
    bit    pres_v = 0;
    bit    infl_v = 0;
    int    ld_seen = 0;
    int    st_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour, evaluated once per cycle away from the clock edge.
    task automatic monitor_step();
        done_t d;
        bit    k;
        if (rst) begin
            mq.delete();
            dq.delete();
            pres_v = 0;
            infl_v = 0;
            return;
        end
        // Completion pulses must match the next predicted completion, on time.
        check("done_exclusive", 64'(ld_done_valid && st_done_valid), 64'(0));
        if (ld_done_valid || st_done_valid) begin
            if (ld_done_valid) ld_seen++;
            if (st_done_valid) st_seen++;
            if (dq.size() == 0) begin
                check("done_unexpected", 64'(1), 64'(0));
            end else begin
                d = dq.pop_front();
                check("done_kind_store", 64'(st_done_valid), 64'(d.is_store));
                check("done_cycle", 64'(cyc), 64'(d.due));
                if (st_done_valid) begin
                    check("st_done_al_id", 64'(st_done_al_id), 64'(d.al));
                end else begin
                    check("ld_done_al_id", 64'(ld_done_al_id), 64'(d.al));
                    check("ld_done_data", 64'(ld_done_data), 64'(d.data));
                end
            end
        end else if (dq.size() > 0 && dq[0].due <= cyc) begin
            check("done_missing", 64'(0), 64'(1));
            void'(dq.pop_front());
        end
        // A response retires the outstanding request; flushed loads produce nothing.
        if (infl_v && cache_resp_valid) begin
            k = infl.killed || (flush && !infl.is_store);
            if (infl.is_store || !k)
                dq.push_back('{infl.is_store, infl.al, cache_resp_data, cyc + 1});
            infl_v = 0;
        end
        // Issue: oldest surviving entry, stable until accepted, one outstanding.
        if (cache_valid) begin
            check("one_outstanding", 64'(infl_v), 64'(0));
            if (!pres_v) begin
                while (mq.size() > 0 && mq[0].killed) void'(mq.pop_front());
                if (mq.size() == 0) begin
                    check("issue_unexpected", 64'(1), 64'(0));
                end else begin
                    pres = mq.pop_front();
                    pres_v = 1;
                end
            end
            if (pres_v) begin
                check("cache_addr", 64'(cache_addr), 64'(pres.addr));
                check("cache_data", 64'(cache_data), 64'(pres.data));
                check("cache_is_store", 64'(cache_is_store), 64'(pres.is_store));
                if (cache_ready) begin
                    infl = pres;
                    infl.killed = pres.killed || (flush && !pres.is_store);
                    infl_v = 1;
                    pres_v = 0;
                end
            end
        end else if (pres_v) begin
            check("issue_dropped", 64'(0), 64'(1));
            pres_v = 0;
        end
        // Flush kills every queued and outstanding load, never stores.
        if (flush) begin
            foreach (mq[i]) if (!mq[i].is_store) mq[i].killed = 1;
            if (pres_v && !pres.is_store) pres.killed = 1;
            if (infl_v && !infl.is_store) infl.killed = 1;
        end
        if (req_valid && req_ready)
            mq.push_back('{req_is_store, req_addr, req_data, req_al_id, 1'b0});
        check("req_ready_rule", 64'(req_ready), 64'(!flush && (occupancy < 3'(DEPTH))));
    endtask

    always @(negedge clk) monitor_step();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic st, input logic [31:0] a,
                           input logic [31:0] dta, input logic [5:0] al);
        req_valid = v;
        req_is_store = st;
        req_addr = a;
        req_data = dta;
        req_al_id = al;
    endtask

    function automatic bit model_has_live();
        foreach (mq[i]) if (!mq[i].killed) return 1;
        return 0;
    endfunction

    // Accept and answer everything until the buffer is empty and quiet.
    task automatic drain(input string tag);
        int n = 0;
        req_valid = 0;
        flush = 0;
        cache_ready = 1;
        while (pres_v || infl_v || dq.size() != 0 || occupancy != 0 || model_has_live()) begin
            if (n >= 300) begin
                check({tag, "_drain_timeout"}, 64'(n), 64'(0));
                break;
            end
            cache_resp_valid = infl_v;
            cache_resp_data = $urandom;
            step();
            n++;
        end
        cache_resp_valid = 0;
        mq.delete();
        check({tag, "_drained_occupancy"}, 64'(occupancy), 64'(0));
    endtask

    initial begin
        int st0;
        int ld0;
        rst = 1;
        set_req(0, 0, 0, 0, 0);
        cache_ready = 0;
        cache_resp_valid = 0;
        cache_resp_data = 0;
        flush = 0;
        repeat (3) step();
        rst = 0;

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_cache_valid", 64'(cache_valid), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_ld_done_valid", 64'(ld_done_valid), 64'(0));
        check("rst_st_done_valid", 64'(st_done_valid), 64'(0));
        check("rst_cache_addr", 64'(cache_addr), 64'(0));
        check("rst_ld_done_data", 64'(ld_done_data), 64'(0));

        // Single load, minimum latency
        set_req(1, 0, 32'h100, 32'h0, 6'd5);
        cache_ready = 1;
        check("t38_req_ready", 64'(req_ready), 64'(1));
        step();
        set_req(0, 0, 0, 0, 0);
        check("t38_cache_valid_next", 64'(cache_valid), 64'(1));
        check("t38_cache_addr", 64'(cache_addr), 64'(32'h100));
        step();
        step();
        cache_resp_valid = 1;
        cache_resp_data = 32'hDEADBEEF;
        step();
        cache_resp_valid = 0;
        check("t38_ld_done_valid", 64'(ld_done_valid), 64'(1));
        check("t38_ld_done_data", 64'(ld_done_data), 64'(32'hDEADBEEF));
        check("t38_ld_done_al_id", 64'(ld_done_al_id), 64'(5));
        step();
        check("t38_ld_done_pulse", 64'(ld_done_valid), 64'(0));

        // Fill to full with the cache stalled, then drain in order across the wrap
        cache_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_req(1, 1'(i % 2), 32'h200 + 32'(i * 4), $urandom, 6'(10 + i));
            check("t39_req_ready", 64'(req_ready), 64'(i < 4));
            step();
        end
        set_req(0, 0, 0, 0, 0);
        check("t39_occupancy_full", 64'(occupancy), 64'(4));
        check("t39_ready_when_full", 64'(req_ready), 64'(0));
        drain("t39");

        // Store ahead of two loads, then flush: store completes, loads vanish
        cache_ready = 0;
        set_req(1, 1, 32'h400, 32'h11, 6'd1); step();
        set_req(1, 0, 32'h404, 32'h22, 6'd2); step();
        set_req(1, 0, 32'h408, 32'h33, 6'd3); step();
        set_req(0, 0, 0, 0, 0);
        flush = 1;
        step();
        flush = 0;
        st0 = st_seen;
        ld0 = ld_seen;
        drain("t40");
        check("t40_st_done_count", 64'(st_seen - st0), 64'(1));
        check("t40_ld_done_count", 64'(ld_seen - ld0), 64'(0));

        // Flush while a load waits for its response
        cache_ready = 1;
        set_req(1, 0, 32'h300, 32'h0, 6'd7); step();
        set_req(0, 0, 0, 0, 0); step();
        flush = 1; step();
        flush = 0;
        cache_resp_valid = 1;
        cache_resp_data = 32'h12345678;
        step();
        cache_resp_valid = 0;
        check("t41_ld_done_suppressed", 64'(ld_done_valid), 64'(0));
        set_req(1, 0, 32'h310, 32'h0, 6'd8);
        step();
        set_req(0, 0, 0, 0, 0);
        check("t41_back_to_idle_issue", 64'(cache_valid), 64'(1));
        drain("t41");

        // Reset during issue, then a stray response
        cache_ready = 0;
        set_req(1, 0, 32'h500, 32'h0, 6'd9); step();
        set_req(0, 0, 0, 0, 0);
        check("t42_in_issue", 64'(cache_valid), 64'(1));
        rst = 1; step();
        rst = 0;
        check("t42_cache_valid", 64'(cache_valid), 64'(0));
        check("t42_occupancy", 64'(occupancy), 64'(0));
        check("t42_req_ready", 64'(req_ready), 64'(1));
        cache_resp_valid = 1;
        cache_resp_data = 32'hCAFE0001;
        step();
        cache_resp_valid = 0;
        check("t42_no_ld_done", 64'(ld_done_valid), 64'(0));
        check("t42_no_st_done", 64'(st_done_valid), 64'(0));
        step();
        check("t42_no_ld_done_late", 64'(ld_done_valid), 64'(0));

        // Simultaneous push and pop at occupancy 2
        cache_ready = 0;
        set_req(1, 1, 32'h600, 32'hA, 6'd20); step();
        set_req(1, 0, 32'h604, 32'hB, 6'd21); step();
        set_req(0, 0, 0, 0, 0);
        check("t43_occupancy_before", 64'(occupancy), 64'(2));
        cache_ready = 1;
        set_req(1, 1, 32'h608, 32'hC, 6'd22);
        step();
        set_req(0, 0, 0, 0, 0);
        cache_ready = 0;
        check("t43_occupancy_after", 64'(occupancy), 64'(2));
        drain("t43");

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            set_req(1'(($urandom % 4) != 0), 1'($urandom % 2), $urandom, $urandom, 6'($urandom));
            flush = 1'(($urandom % 20) == 0);
            cache_ready = 1'(($urandom % 3) != 0);
            cache_resp_valid = infl_v ? 1'($urandom % 2) : 1'(($urandom % 16) == 0);
            cache_resp_data = $urandom;
            step();
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
